// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-compatible PIC acknowledge/in-service logic.
package pic_pkg;

   localparam int PIC_LEVELS  = 8;
   localparam int PIC_LEVEL_W = 3;

   localparam logic [PIC_LEVEL_W-1:0] SPURIOUS_LEVEL    = 3'd7;
   localparam logic [PIC_LEVEL_W-1:0] LAST_SERVICED_RST = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ACK1,
      WAIT2,
      ACK2
   } ack_state_e;

   function automatic logic [PIC_LEVELS-1:0] levelOneHot(input logic [PIC_LEVEL_W-1:0] level);
      logic [PIC_LEVELS-1:0] mask;
      mask        = '0;
      mask[level] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/pic_isr_eoi_select.sv
// Rotated priority search over the ISR: the first set bit found walking up from
// last_i+1 (wrapping) is the level a non-specific EOI clears.
module pic_isr_eoi_select
   import pic_pkg::*;
(
   input  logic [PIC_LEVELS-1:0]  isr_i,
   input  logic [PIC_LEVEL_W-1:0] last_i,
   output logic [PIC_LEVEL_W-1:0] level_o,
   output logic                   valid_o
);

   always_comb begin
      logic [PIC_LEVEL_W-1:0] idx;
      level_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      // k = PIC_LEVELS wraps back to last_i itself, so it is searched last
      for (int k = 1; k <= PIC_LEVELS; k++) begin
         idx = last_i + PIC_LEVEL_W'(k);
         if (!valid_o && isr_i[idx]) begin
            level_o = idx;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pic_ack_sequencer.sv
// CPU-side INT/INTA handshake, In-Service Register and EOI handling for the PIC.
// Optional automatic EOI on the second INTA rising edge is enabled by PIC_AEOI_EN.
module pic_ack_sequencer
   import pic_pkg::*;
#(
   parameter int VEC_W = 8
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   intflag,
   input  logic [PIC_LEVEL_W-1:0] priority_id,
   input  logic                   inta_n,
   input  logic [4:0]             vector_base,
   input  logic                   eoi_valid,
   input  logic                   eoi_specific,
   input  logic [PIC_LEVEL_W-1:0] eoi_level,
   input  logic                   rotate_on_eoi,
   output logic                   int_out,
   output logic [PIC_LEVELS-1:0]  isr,
   output logic [PIC_LEVELS-1:0]  irr_clear,
   output logic [VEC_W-1:0]       data_out,
   output logic                   data_oe,
   output logic [PIC_LEVEL_W-1:0] last_serviced
);

   ack_state_e               state_q;
   logic                     intaPrev_q;
   logic [PIC_LEVEL_W-1:0]   id_q;
   logic                     intOut_q;
   logic [PIC_LEVELS-1:0]    isr_q, isr_d, isrAeoi;
   logic [PIC_LEVELS-1:0]    irrClear_q;
   logic [VEC_W-1:0]         dataOut_q;
   logic                     dataOe_q;
   logic [PIC_LEVEL_W-1:0]   lastServiced_q, lastServiced_d, lastAeoi;
   logic                     intaFall, intaRise, ackSet;
   logic [PIC_LEVEL_W-1:0]   selLevel;
   logic                     selValid;
`ifdef PIC_AEOI_EN
   logic                     spurious_q;
`endif

   assign intaFall = intaPrev_q & ~inta_n;
   assign intaRise = ~intaPrev_q & inta_n;
   assign ackSet   = (state_q == REQ) && intaFall && intflag;

   // Automatic EOI stage; a same-cycle EOI strobe is applied on top of its result
   always_comb begin
      isrAeoi  = isr_q;
      lastAeoi = lastServiced_q;
`ifdef PIC_AEOI_EN
      if ((state_q == ACK2) && intaRise && !spurious_q) begin
         isrAeoi[id_q] = 1'b0;
         if (rotate_on_eoi) lastAeoi = id_q;
      end
`endif
   end

   pic_isr_eoi_select u_select (
      .isr_i   (isrAeoi),
      .last_i  (lastAeoi),
      .level_o (selLevel),
      .valid_o (selValid)
   );

   // EOI uses the pre-set ISR; setting the acknowledged bit last makes the set win a tie
   always_comb begin
      isr_d          = isrAeoi;
      lastServiced_d = lastAeoi;
      if (eoi_valid) begin
         if (eoi_specific) begin
            if (isrAeoi[eoi_level]) begin
               isr_d[eoi_level] = 1'b0;
               if (rotate_on_eoi) lastServiced_d = eoi_level;
            end
         end else if (selValid) begin
            isr_d[selLevel] = 1'b0;
            if (rotate_on_eoi) lastServiced_d = selLevel;
         end
      end
      if (ackSet) isr_d = isr_d | levelOneHot(priority_id);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         intaPrev_q     <= 1'b1;
         id_q           <= SPURIOUS_LEVEL;
         intOut_q       <= 1'b0;
         isr_q          <= '0;
         irrClear_q     <= '0;
         dataOut_q      <= '0;
         dataOe_q       <= 1'b0;
         lastServiced_q <= LAST_SERVICED_RST;
`ifdef PIC_AEOI_EN
         spurious_q     <= 1'b0;
`endif
      end else begin
         intaPrev_q     <= inta_n;
         irrClear_q     <= '0;
         isr_q          <= isr_d;
         lastServiced_q <= lastServiced_d;
         case (state_q)
            IDLE: begin
               if (intflag) begin
                  state_q  <= REQ;
                  intOut_q <= 1'b1;
               end
            end
            REQ: begin
               // A falling edge takes precedence over a dropped request: that is the spurious case
               if (intaFall) begin
                  state_q  <= ACK1;
                  intOut_q <= 1'b0;
                  id_q     <= intflag ? priority_id : SPURIOUS_LEVEL;
                  if (intflag) irrClear_q <= levelOneHot(priority_id);
`ifdef PIC_AEOI_EN
                  spurious_q <= ~intflag;
`endif
               end else if (!intflag) begin
                  state_q  <= IDLE;
                  intOut_q <= 1'b0;
               end
            end
            ACK1: begin
               if (intaRise) state_q <= WAIT2;
            end
            WAIT2: begin
               if (intaFall) begin
                  state_q   <= ACK2;
                  dataOe_q  <= 1'b1;
                  dataOut_q <= VEC_W'({vector_base, id_q});
               end
            end
            ACK2: begin
               if (intaRise) begin
                  state_q   <= IDLE;
                  dataOe_q  <= 1'b0;
                  dataOut_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign int_out       = intOut_q;
   assign isr           = isr_q;
   assign irr_clear     = irrClear_q;
   assign data_out      = dataOut_q;
   assign data_oe       = dataOe_q;
   assign last_serviced = lastServiced_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Table-driven bench for pic_ack_sequencer: each row is one clock of inputs plus the
// outputs expected after that edge. Honours PIC_AEOI_EN when the design is built with it.
module tb_pic_ack_sequencer;

   localparam logic [4:0] VECTOR_BASE = 5'h08;

   typedef struct {
      logic       rst;
      logic       flag;
      logic [2:0] pid;
      logic       inta;
      logic       eoiV;
      logic       eoiS;
      logic [2:0] eoiL;
      logic       rot;
      logic       intO;
      logic [7:0] isr;
      logic [7:0] irrc;
      logic [7:0] dout;
      logic       doe;
      logic [2:0] last;
   } vec_t;

   typedef struct {
      logic       intO;
      logic [7:0] isr;
      logic [7:0] irrc;
      logic [7:0] dout;
      logic       doe;
      logic [2:0] last;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       intflag;
   logic [2:0] priorityId;
   logic       intaN;
   logic [4:0] vectorBase;
   logic       eoiValid;
   logic       eoiSpecific;
   logic [2:0] eoiLevel;
   logic       rotateOnEoi;
   logic       intOut;
   logic [7:0] isr;
   logic [7:0] irrClear;
   logic [7:0] dataOut;
   logic       dataOe;
   logic [2:0] lastServiced;

   vec_t vecs[$];
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   pic_ack_sequencer #(.VEC_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .intflag       (intflag),
      .priority_id   (priorityId),
      .inta_n        (intaN),
      .vector_base   (vectorBase),
      .eoi_valid     (eoiValid),
      .eoi_specific  (eoiSpecific),
      .eoi_level     (eoiLevel),
      .rotate_on_eoi (rotateOnEoi),
      .int_out       (intOut),
      .isr           (isr),
      .irr_clear     (irrClear),
      .data_out      (dataOut),
      .data_oe       (dataOe),
      .last_serviced (lastServiced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addRow(input logic rst, input logic flag, input logic [2:0] pid, input logic inta,
                         input logic eoiV, input logic eoiS, input logic [2:0] eoiL, input logic rot,
                         input logic intO, input logic [7:0] isrE, input logic [7:0] irrc,
                         input logic [7:0] dout, input logic doe, input logic [2:0] last);
      vec_t v;
      v.rst = rst;   v.flag = flag; v.pid = pid;   v.inta = inta;
      v.eoiV = eoiV; v.eoiS = eoiS; v.eoiL = eoiL; v.rot = rot;
      v.intO = intO; v.isr = isrE;  v.irrc = irrc; v.dout = dout; v.doe = doe; v.last = last;
      vecs.push_back(v);
   endtask

   // Six-cycle acknowledge: request, first INTA low/high, second INTA low/high
   task automatic addAck(input logic [2:0] pid, input logic flagAtFall,
                         input logic [7:0] isrPre, input logic [7:0] isrPost,
                         input logic [2:0] last, input logic rot,
                         input logic eoiV, input logic eoiS, input logic [2:0] eoiL);
      logic [7:0] irrExp;
      logic [2:0] vecLvl;
      logic [7:0] vecVal;
      logic [7:0] isrEnd;
      logic [2:0] lastEnd;
      irrExp  = flagAtFall ? (8'h01 << pid) : 8'h00;
      vecLvl  = flagAtFall ? pid : 3'd7;
      vecVal  = {VECTOR_BASE, vecLvl};
      isrEnd  = isrPost;
      lastEnd = last;
`ifdef PIC_AEOI_EN
      if (flagAtFall) begin
         isrEnd = isrPost & ~irrExp;
         if (rot) lastEnd = pid;
      end
`endif
      addRow(0, 1,          pid, 1, 0,    0,    0,    rot, 1, isrPre,  8'h00,  8'h00,  0, last);
      addRow(0, flagAtFall, pid, 0, eoiV, eoiS, eoiL, rot, 0, isrPost, irrExp, 8'h00,  0, last);
      addRow(0, 0,          pid, 0, 0,    0,    0,    rot, 0, isrPost, 8'h00,  8'h00,  0, last);
      addRow(0, 0,          pid, 1, 0,    0,    0,    rot, 0, isrPost, 8'h00,  8'h00,  0, last);
      addRow(0, 0,          pid, 0, 0,    0,    0,    rot, 0, isrPost, 8'h00,  vecVal, 1, last);
      addRow(0, 0,          pid, 1, 0,    0,    0,    rot, 0, isrEnd,  8'h00,  8'h00,  0, lastEnd);
   endtask

   task automatic buildTable();
      addRow(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
`ifdef PIC_AEOI_EN
      addAck(3'd6, 1, 8'h00, 8'h40, 3'd7, 1, 0, 0, 0);
      addRow(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd6);
      addAck(3'd3, 1, 8'h00, 8'h08, 3'd6, 0, 0, 0, 0);
`else
      // Normal acknowledge of IR3, then IR1 to build ISR 0x0A
      addAck(3'd3, 1, 8'h00, 8'h08, 3'd7, 0, 0, 0, 0);
      addRow(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h08, 8'h00, 8'h00, 0, 3'd7);
      addAck(3'd1, 1, 8'h08, 8'h0A, 3'd7, 0, 0, 0, 0);
      // Fully nested non-specific EOIs, the last one a no-op
      addRow(0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h08, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      // Build ISR 0x31, rotate last_serviced to 4 with a specific EOI, then rotating EOI
      addAck(3'd4, 1, 8'h00, 8'h10, 3'd7, 0, 0, 0, 0);
      addAck(3'd5, 1, 8'h10, 8'h30, 3'd7, 0, 0, 0, 0);
      addAck(3'd0, 1, 8'h30, 8'h31, 3'd7, 0, 0, 0, 0);
      addRow(0, 0, 0, 1, 1, 1, 3'd4, 1, 0, 8'h21, 8'h00, 8'h00, 0, 3'd4);
      addRow(0, 0, 0, 1, 1, 0, 0,    1, 0, 8'h01, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 0, 0, 1, 1, 1, 3'd3, 1, 0, 8'h01, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 0, 0, 1, 1, 0, 0,    0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd5);
      // Specific EOI and ISR set on the same bit in one cycle: the set wins
      addAck(3'd2, 1, 8'h00, 8'h04, 3'd5, 0, 0, 0, 0);
      addAck(3'd2, 1, 8'h04, 8'h04, 3'd5, 0, 1, 1, 3'd2);
      // Non-specific EOI alongside a new set searches the pre-set ISR (clears IR2, not IR1)
      addAck(3'd1, 1, 8'h04, 8'h02, 3'd5, 0, 1, 0, 0);
      // Spurious: request withdrawn on the very cycle of the first falling edge
      addAck(3'd6, 0, 8'h02, 8'h02, 3'd5, 0, 0, 0, 0);
      // Request withdrawn before any INTA, then a stray falling edge in IDLE
      addRow(0, 1, 3'd4, 1, 0, 0, 0, 0, 1, 8'h02, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 3'd5);
      // Reset while waiting for the second pulse, then a pulse that must be ignored
      addRow(0, 1, 3'd4, 1, 0, 0, 0, 0, 1, 8'h02, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 1, 3'd4, 0, 0, 0, 0, 0, 0, 8'h12, 8'h10, 8'h00, 0, 3'd5);
      addRow(0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00, 0, 3'd5);
      addRow(0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00, 0, 3'd5);
      addRow(1, 0, 3'd4, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
      addRow(0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7);
`endif
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      reset       = v.rst;
      intflag     = v.flag;
      priorityId  = v.pid;
      intaN       = v.inta;
      eoiValid    = v.eoiV;
      eoiSpecific = v.eoiS;
      eoiLevel    = v.eoiL;
      rotateOnEoi = v.rot;
      e.intO = v.intO; e.isr = v.isr; e.irrc = v.irrc;
      e.dout = v.dout; e.doe = v.doe; e.last = v.last;
      expQ.push_back(e);
   endtask

   task automatic checkField(input string name, input int row, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s row %0d: got %h, expected %h", name, row, act, req);
      end
   endtask

   task automatic checkOutput(input int row);
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard row %0d: got empty queue, expected an entry", row);
      end else begin
         e = expQ.pop_front();
         checkField("int_out",       row, {7'd0, intOut},       {7'd0, e.intO});
         checkField("isr",           row, isr,                  e.isr);
         checkField("irr_clear",     row, irrClear,             e.irrc);
         checkField("data_out",      row, dataOut,              e.dout);
         checkField("data_oe",       row, {7'd0, dataOe},       {7'd0, e.doe});
         checkField("last_serviced", row, {5'd0, lastServiced}, {5'd0, e.last});
      end
   endtask

   initial begin
      reset       = 1'b1;
      intflag     = 1'b0;
      priorityId  = 3'd0;
      intaN       = 1'b1;
      vectorBase  = VECTOR_BASE;
      eoiValid    = 1'b0;
      eoiSpecific = 1'b0;
      eoiLevel    = 3'd0;
      rotateOnEoi = 1'b0;
      buildTable();
      $display("[TB] applying %0d vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput(i);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Interrupt acknowledge and in-service controller for the 8259-compatible PIC, consuming the resolved `PriorityID`/`INTFLAG` pair and running the CPU side of the handshake. It raises INT, tracks the two-pulse INTA sequence (8086 mode), owns the In-Service Register, clears the winning IRR bit, drives the interrupt vector, processes EOI commands and maintains `last_serviced` for rotation. Its `isr` and `last_serviced` outputs feed back into the priority resolver, closing the loop.

## Interface
- `VEC_W`, 8: data bus / vector width.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `intflag` in 1: a request won priority resolution.
- `priority_id` in 3: winning IR level.
- `inta_n` in 1: CPU acknowledge, active low; synchronous to `clk`, each level held ≥2 cycles.
- `vector_base` in 5: ICW2 T7..T3.
- `eoi_valid` in 1: one-cycle OCW2 EOI strobe.
- `eoi_specific` in 1: 1 = specific EOI, 0 = non-specific.
- `eoi_level` in 3: level for a specific EOI.
- `rotate_on_eoi` in 1: update `last_serviced` when an EOI clears a bit.
- `int_out` out 1: INT to the CPU.
- `isr` out 8: In-Service Register.
- `irr_clear` out 8: one-hot, one-cycle pulse clearing the acknowledged IRR bit.
- `data_out` out VEC_W: vector value.
- `data_oe` out 1: data bus drive enable.
- `last_serviced` out 3: last serviced level, used for rotation.

## Operation
- Edge detection: a one-cycle-delayed copy of `inta_n`. Falling edge = previous 1, current 0. Rising edge = previous 0, current 1.
- States and transitions:
  - IDLE: go to REQ when `intflag`=1.
  - REQ: `int_out`=1.
    - If `intflag` falls before an INTA falling edge, return to IDLE.
    - On an INTA falling edge, latch `id`, set `isr[id]`, pulse `irr_clear[id]`, then go to ACK1.
  - ACK1: wait for an INTA rising edge, then go to WAIT2.
  - WAIT2: on an INTA falling edge, go to ACK2 and assert `data_oe` with `data_out` = {`vector_base`, `id`}.
  - ACK2: on an INTA rising edge, deassert `data_oe` and return to IDLE.
- Spurious acknowledge: if `intflag`=0 on the first falling edge, `id`=7, no ISR bit is set and no `irr_clear` pulse is issued. The vector still uses level 7.
- Non-specific EOI clears the highest-priority set ISR bit. The search starts at `last_serviced`+1 mod 8 and wraps.
  - With `rotate_on_eoi`=0 and `last_serviced`=7 this gives fully nested order (IR0 highest).
  - If no ISR bit is set, a non-specific EOI is a no-op.
- Specific EOI clears `isr[eoi_level]`; if that bit is already clear, nothing changes.
- `last_serviced` takes the cleared level only if `rotate_on_eoi`=1 and a bit was actually cleared.
- Same-cycle EOI and ISR set:
  - The EOI search uses the pre-set ISR value.
  - If both target the same bit, the set wins.
- Unexpected INTA edges are ignored: falling edges in IDLE, rising edges in REQ/WAIT2.

## Timing
- Reset values: `int_out`=0, `isr`=0, `irr_clear`=0, `data_out`=0, `data_oe`=0, `last_serviced`=7, state IDLE.
- Reset mid-sequence aborts the sequence: the bus is released and the ISR is cleared.
- `int_out` rises 1 cycle after `intflag` is sampled high in IDLE. It falls on the cycle after the first INTA falling edge is detected.
- `isr` set and `irr_clear` take effect 1 cycle after that falling edge is detected; `irr_clear` lasts exactly 1 cycle.
- `data_oe` and `data_out` are valid 1 cycle after the second falling edge is detected, and drop 1 cycle after the rising edge is detected.
  - `data_out` returns to 0 when released.
- EOI effects are visible on `isr` and `last_serviced` 1 cycle after `eoi_valid`.

## Configuration
- `PIC_AEOI_EN` defined:
  - At the second INTA rising edge, `isr[id]` clears automatically.
  - `last_serviced` takes `id` when `rotate_on_eoi`=1.
  - An EOI strobe arriving in that same cycle is applied after the AEOI clear.
- `PIC_AEOI_EN` undefined: ISR bits clear only via `eoi_valid`.

## Structure
- Package `pic_pkg` holds:
  - state enum (IDLE, REQ, ACK1, WAIT2, ACK2);
  - `PIC_LEVELS`=8, `PIC_LEVEL_W`=3;
  - `SPURIOUS_LEVEL`=3'd7;
  - reset constant for `last_serviced`.
- Sub-module `pic_isr_eoi_select`: combinational rotated priority search over the ISR, returning the found level and a valid flag for non-specific EOI.

## Test plan
- Normal acknowledge: `intflag`=1, `priority_id`=3, `vector_base`=5'h08, two INTA pulses. Expect `int_out` 0→1→0, `irr_clear`=8'h08 for 1 cycle, `isr`=8'h08, `data_out`=8'h43 with `data_oe`=1 during the second pulse.
- Nested EOI: `isr`=8'h0A, `last_serviced`=7, non-specific EOI. Expect `isr`=8'h08; a second EOI gives 8'h00; a third EOI is a no-op.
- Rotating EOI: `isr`=8'h21, `last_serviced`=4, `rotate_on_eoi`=1, non-specific EOI. Expect `isr`=8'h01, `last_serviced`=5.
- Spurious: `intflag` drops before the first falling edge while in REQ (not returned to IDLE). Expect no `irr_clear`, `isr` unchanged, vector {`vector_base`,3'd7}.
- Mid-sequence reset: assert `reset` in WAIT2. Next cycle expect all outputs at reset values and a subsequent INTA pulse ignored.
- With `PIC_AEOI_EN`: acknowledge level 6 with `rotate_on_eoi`=1. Expect `isr`=8'h00 one cycle after the second rising edge and `last_serviced`=6.
